// File: rtl/fifo_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and sizing helpers for the audio FIFO write
//                arbiter and its round-robin picker.
//                - arb_state_t : arbiter state encoding (IDLE/BURST/STALL)
//                - id_width    : producer tag width for a requester count
//                - beat_width  : burst beat counter width for a burst length
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    // Width of the producer statistics counters
    localparam int STAT_W = 16;

    // A single requester still needs one tag bit to keep the data bus legal
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int beat_width(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first asserted
//                request at or after the pointer, wrapping at NUM_REQ.
//  Ports       : i_req_valid [NUM_REQ]  request vector
//                i_rr_ptr    [ID_W]     highest-priority index this round
//                o_any       [1]        at least one request asserted
//                o_index     [ID_W]     winning index (0 when o_any=0)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_index
);

    logic [ID_W-1:0] w_pos;

    // Scan from the far end back towards the pointer so the last hit written
    // is the one closest to (at or after) the pointer.
    always_comb begin
        o_any   = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (i_req_valid[w_pos]) begin
                o_any   = 1'b1;
                o_index = w_pos;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fifo_write_arbiter
//  Description : Round-robin arbiter sharing the write port of the dual-clock
//                audio FIFO among NUM_REQ producers. A grant covers one burst
//                of up to BURST_LEN words so frames stay contiguous; every
//                word is tagged with the producer ID: {id, payload}.
//  Ports       : WClk, PresetFull (async, active-high)
//                req_valid/req_last [NUM_REQ], req_data [NUM_REQ*DATA_WIDTH]
//                req_ready [NUM_REQ]
//                fifo_full -> fifo_wr_en, fifo_wr_data [ID_W+DATA_WIDTH]
//                flush (sync burst abort), busy (state != IDLE)
//  Options     : FIFO_ARB_STATS_EN adds stat_sel / stat_stall_cnt and one
//                16-bit saturating wait counter per producer.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 2,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          WClk,
    input  logic                          PresetFull,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_wr_data,
    input  logic                          flush,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]               stat_sel,
    output logic [STAT_W-1:0]             stat_stall_cnt
`endif
);

    localparam int                BEAT_W    = beat_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]   MAX_ID    = ID_W'(NUM_REQ - 1);

    arb_state_t        state_q,    state_d;
    logic [ID_W-1:0]   grant_q,    grant_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              w_pick_any;
    logic [ID_W-1:0]   w_pick_idx;
    logic              w_grant_valid;
    logic              w_grant_last;
    logic              w_accept_open;
    logic              w_burst_end;
    logic [ID_W-1:0]   w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req_valid (req_valid),
        .i_rr_ptr    (rr_ptr_q),
        .o_any       (w_pick_any),
        .o_index     (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Datapath and handshake
    // ------------------------------------------------------------------
    assign w_grant_valid = req_valid[grant_q];
    assign w_grant_last  = req_last[grant_q];

    // Flush blocks acceptance on its own cycle so no word is half-consumed.
    assign w_accept_open = (state_q == ST_BURST) && !fifo_full && !flush;

    assign req_ready    = w_accept_open ? (NUM_REQ'(1) << grant_q) : '0;
    assign fifo_wr_en   = w_accept_open && w_grant_valid;
    assign fifo_wr_data = {grant_q, req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH]};
    assign busy         = (state_q != ST_IDLE);

    assign w_next_ptr  = (grant_q == MAX_ID) ? '0 : grant_q + ID_W'(1);
    assign w_burst_end = fifo_wr_en && (w_grant_last || (beat_cnt_q == LAST_BEAT));

    // ------------------------------------------------------------------
    // Arbitration state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        if (flush) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = w_next_ptr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Grant is registered here; the first word can only be
                    // taken on the following cycle.
                    if (w_pick_any) begin
                        grant_d    = w_pick_idx;
                        beat_cnt_d = '0;
                        state_d    = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (fifo_wr_en) begin
                        if (w_burst_end) begin
                            state_d    = ST_IDLE;
                            beat_cnt_d = '0;
                            rr_ptr_d   = w_next_ptr;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end else if (fifo_full && w_grant_valid) begin
                        state_d = ST_STALL;
                    end
                    // A producer that drops valid mid-burst keeps its grant.
                end
                ST_STALL: begin
                    if (!fifo_full) begin
                        state_d = ST_BURST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge WClk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-producer wait counters: cycles with a word offered but not taken
    // ------------------------------------------------------------------
    logic [STAT_W-1:0] stall_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_d [NUM_REQ];
    logic [STAT_W-1:0] stat_rd_q,  stat_rd_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_cnt_d[i] = stall_cnt_q[i];
            if (req_valid[i] && !req_ready[i] && (stall_cnt_q[i] != {STAT_W{1'b1}})) begin
                stall_cnt_d[i] = stall_cnt_q[i] + STAT_W'(1);
            end
        end
        stat_rd_d = (int'(stat_sel) < NUM_REQ) ? stall_cnt_q[stat_sel] : '0;
    end

    always_ff @(posedge WClk or posedge PresetFull) begin
        if (PresetFull) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stall_cnt_q[i] <= '0;
            end
            stat_rd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_stall_cnt = stat_rd_q;
`endif

endmodule : fifo_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fifo_write_arbiter
//  Description : Self-checking bench for fifo_write_arbiter (4 producers,
//                16-bit payload, 2-word bursts). A cycle-level behavioural
//                model checks every output on every falling edge; directed
//                sequences pin grant order, stall, last, flush and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 2;
    localparam int IW = 2;

    logic              WClk = 1'b0;
    logic              PresetFull = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [IW+DW-1:0]  fifo_wr_data;
    logic              flush = 1'b0;
    logic              busy;
`ifdef FIFO_ARB_STATS_EN
    logic [IW-1:0]     stat_sel = '0;
    logic [15:0]       stat_stall_cnt;
`endif

    always #5 WClk = ~WClk;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .WClk         (WClk),
        .PresetFull   (PresetFull),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .flush        (flush),
        .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel       (stat_sel),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who holds the port, how many words they have sent,
    // whether they are parked on a full FIFO, and who goes first next time.
    // ------------------------------------------------------------------
    bit m_active  = 0;
    bit m_stalled = 0;
    int m_grant   = 0;
    int m_ptr     = 0;
    int m_sent    = 0;

    initial begin
        forever begin
            logic [N-1:0] e_ready;
            logic         e_wr;
            logic [IW-1:0] e_tag;
            bit           found;
            @(negedge WClk);
            e_ready = '0;
            e_wr    = 1'b0;
            e_tag   = m_grant[IW-1:0];
            if (!PresetFull && m_active && !m_stalled && !fifo_full && !flush) begin
                e_ready[m_grant] = 1'b1;
                e_wr             = req_valid[m_grant];
            end
            check("model_ready", req_ready, e_ready);
            check("model_wr_en", fifo_wr_en, e_wr);
            check("model_busy", busy, !PresetFull && m_active);
            if (e_wr) check("model_wr_data", fifo_wr_data, {e_tag, req_data[m_grant*DW +: DW]});

            if (PresetFull) begin
                m_active = 0; m_stalled = 0; m_grant = 0; m_ptr = 0; m_sent = 0;
            end else if (flush) begin
                m_active = 0; m_stalled = 0; m_ptr = (m_grant + 1) % N; m_sent = 0;
            end else if (!m_active) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1; m_grant = (m_ptr + k) % N;
                    end
                end
                if (found) begin m_active = 1; m_sent = 0; end
            end else if (m_stalled) begin
                if (!fifo_full) m_stalled = 0;
            end else if (e_wr) begin
                m_sent++;
                if (req_last[m_grant] || m_sent == BL) begin
                    m_active = 0; m_ptr = (m_grant + 1) % N; m_sent = 0;
                end
            end else if (fifo_full && req_valid[m_grant]) begin
                m_stalled = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    logic          s_wr, s_busy;
    logic [N-1:0]  s_ready;
    int            tags[$];

    task automatic tick();
        @(negedge WClk);
        s_wr    = fifo_wr_en;
        s_busy  = busy;
        s_ready = req_ready;
        if (fifo_wr_en) tags.push_back(int'(fifo_wr_data[DW +: IW]));
        @(posedge WClk);
        #1;
    endtask

    task automatic do_reset();
        PresetFull = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; flush = 1'b0;
        tick(); tick();
        PresetFull = 1'b0;
    endtask

    function automatic int tag_at(input int i);
        return (i < tags.size()) ? tags[i] : -1;
    endfunction

    int exp_rr[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int wr_in_full;

    initial begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(16'hA000 + i);

        // Reset state
        tick();
        check("reset_busy", s_busy, 1'b0);
        check("reset_wr_en", s_wr, 1'b0);
        check("reset_ready", s_ready, '0);
        tick();
        PresetFull = 1'b0;

        // All four producers busy: strict rotation, one idle cycle per burst
        req_valid = 4'hF;
        tags.delete();
        for (int c = 0; c < 15; c++) begin
            tick();
            check("rr_wr_pattern", s_wr, (c % 3) != 0);
        end
        check("rr_count", tags.size(), 10);
        for (int i = 0; i < 10; i++) check("rr_tag", tag_at(i), exp_rr[i]);

        // Async reset in the middle of producer 1's burst
        tick(); tick();
        check("mid_burst_wr", s_wr, 1'b1);
        check("mid_burst_tag", tag_at(tags.size() - 1), 1);
        PresetFull = 1'b1;
        tick();
        check("async_rst_wr_en", s_wr, 1'b0);
        check("async_rst_ready", s_ready, '0);
        check("async_rst_busy", s_busy, 1'b0);
        PresetFull = 1'b0;
        tags.delete();
        tick(); tick(); tick();
        check("post_rst_grant", tag_at(0), 0);

        // Stall on a full FIFO after the first beat; producer 2 must wait
        do_reset();
        req_valid = 4'b0110;
        tags.delete();
        tick(); tick();
        fifo_full = 1'b1;
        wr_in_full = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            wr_in_full += int'(s_wr);
            check("stall_busy", s_busy, 1'b1);
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("stall_no_write", wr_in_full, 0);
        check("stall_beat0", tag_at(0), 1);
        check("stall_beat1", tag_at(1), 1);
        check("stall_next", tag_at(2), 2);

        // Last marker ends a burst after one word and advances the pointer
        do_reset();
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        tags.delete();
        for (int c = 0; c < 6; c++) tick();
        check("last_count", tags.size(), 3);
        check("last_tag0", tag_at(0), 0);
        check("last_tag1", tag_at(1), 1);
        check("last_tag2", tag_at(2), 0);

        // Flush after the first beat
        do_reset();
        req_valid = 4'hF;
        tick(); tick();
        flush = 1'b1;
        tick();
        check("flush_no_wr", s_wr, 1'b0);
        flush = 1'b0;
        tick();
        check("flush_idle", s_busy, 1'b0);
        tags.delete();
        tick();
        check("flush_next_wr", s_wr, 1'b1);
        check("flush_next_grant", tag_at(0), 1);

`ifdef FIFO_ARB_STATS_EN
        // Producer 3 offers words for 10 cycles and none is taken
        do_reset();
        stat_sel  = 2'd3;
        req_valid = 4'b1000;
        fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        req_valid = '0;
        fifo_full = 1'b0;
        tick(); tick();
        check("stat_cnt3", stat_stall_cnt, 16'd10);
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid  = N'($urandom);
            req_last   = N'($urandom) & N'($urandom);
            req_data   = {$urandom, $urandom};
            fifo_full  = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            PresetFull = ($urandom_range(0, 499) == 0);
            tick();
        end
        PresetFull = 1'b0;
        flush      = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_write_arbiter
`default_nettype wire
